// File: rtl/board_test_pkg.sv
// ---------------------------------------------------------------------------
// board_test_pkg
// Shared definitions for the board-test button conditioning logic.
//   btn_state_e          : per-button debounce/classification FSM states
//   DEBOUNCE_CYCLES_DEF  : default stable-sample count (20 ms at 2.5 MHz)
//   LONG_CYCLES_DEF      : default long-press hold time (1 s at 2.5 MHz)
// ---------------------------------------------------------------------------
package board_test_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESS_WAIT   = 3'd1,
      HELD         = 3'd2,
      LONG_HELD    = 3'd3,
      RELEASE_WAIT = 3'd4
   } btn_state_e;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 50_000;
   localparam int unsigned LONG_CYCLES_DEF     = 2_500_000;

endpackage

// File: rtl/board_test_button_channel.sv
// ---------------------------------------------------------------------------
// board_test_button_channel
// One push-button: 2-FF synchroniser, debounce FSM, debounce counter and
// long-press counter.
//   int_clock        in  clock, all logic on posedge
//   rst              in  asynchronous active-low reset
//   btn_i            in  raw button, active-low, bouncing
//   pressed_o        out debounced level, active-high (registered)
//   pressed_d_o      out next-cycle value of pressed_o (for chord detection)
//   press_pulse_o    out one-cycle pulse on accepted press
//   release_pulse_o  out one-cycle pulse on accepted release
//   long_pulse_o     out one-cycle pulse once per press after LONG_CYCLES
// ---------------------------------------------------------------------------
module board_test_button_channel
   import board_test_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic int_clock,
   input  logic rst,
   input  logic btn_i,
   output logic pressed_o,
   output logic pressed_d_o,
   output logic press_pulse_o,
   output logic release_pulse_o,
   output logic long_pulse_o
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int LONG_W = $clog2(LONG_CYCLES + 1);

   // The sample that leaves IDLE/HELD/LONG_HELD is the first stable sample, so
   // the counter only has to cover the remaining DEBOUNCE_CYCLES-1 samples:
   // the change is accepted when it reads DEBOUNCE_CYCLES-2 on a stable sample.
   localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
   localparam logic [CNT_W-1:0]  DB_MAX    = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
   localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

   if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
      $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
   end

   logic              sync1_q, sync2_q;
   logic              sp;
   btn_state_e        state_q, state_d;
   logic [CNT_W-1:0]  db_cnt_q, db_cnt_d, db_inc;
   logic [LONG_W-1:0] long_cnt_q, long_cnt_d, long_inc;
   logic              from_long_q, from_long_d;
   logic              pressed_q, pressed_d;
   logic              press_pulse_q, press_pulse_d;
   logic              release_pulse_q, release_pulse_d;
   logic              long_pulse_q, long_pulse_d;

   // Synchroniser resets to 1 so a reset looks like a released button.
   always_ff @(posedge int_clock or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   assign sp       = ~sync2_q;
   assign db_inc   = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + CNT_W'(1);
   assign long_inc = (long_cnt_q == LONG_MAX) ? long_cnt_q : long_cnt_q + LONG_W'(1);

   always_ff @(posedge int_clock or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         db_cnt_q        <= '0;
         long_cnt_q      <= '0;
         from_long_q     <= 1'b0;
         pressed_q       <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         db_cnt_q        <= db_cnt_d;
         long_cnt_q      <= long_cnt_d;
         from_long_q     <= from_long_d;
         pressed_q       <= pressed_d;
         press_pulse_q   <= press_pulse_d;
         release_pulse_q <= release_pulse_d;
         long_pulse_q    <= long_pulse_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      db_cnt_d        = '0;
      // Long counter runs whenever the debounced level is high, including
      // while a release is being qualified.
      long_cnt_d      = pressed_q ? long_inc : long_cnt_q;
      from_long_d     = from_long_q;
      pressed_d       = pressed_q;
      press_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      long_pulse_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (sp) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!sp) begin
               state_d = IDLE;
            end else if (db_cnt_q == DB_LAST) begin
               state_d       = HELD;
               pressed_d     = 1'b1;
               press_pulse_d = 1'b1;
               long_cnt_d    = '0;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         HELD: begin
            if (!sp) begin
               state_d     = RELEASE_WAIT;
               from_long_d = 1'b0;
            end else if (long_cnt_q >= LONG_LAST) begin
               // >= so a hold that matured during a rejected release glitch
               // still fires once on return.
               state_d      = LONG_HELD;
               long_pulse_d = 1'b1;
            end
         end
         LONG_HELD: begin
            if (!sp) begin
               state_d     = RELEASE_WAIT;
               from_long_d = 1'b1;
            end
         end
         RELEASE_WAIT: begin
            if (sp) begin
               state_d = from_long_q ? LONG_HELD : HELD;
            end else if (db_cnt_q == DB_LAST) begin
               state_d         = IDLE;
               pressed_d       = 1'b0;
               release_pulse_d = 1'b1;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pressed_o       = pressed_q;
   assign pressed_d_o     = pressed_d;
   assign press_pulse_o   = press_pulse_q;
   assign release_pulse_o = release_pulse_q;
   assign long_pulse_o    = long_pulse_q;

endmodule

// File: rtl/board_test_button_conditioner.sv
// ---------------------------------------------------------------------------
// board_test_button_conditioner
// Turns the raw s1/s2 push-buttons into debounced levels and event pulses.
//   int_clock      in  clock, all logic on posedge
//   rst            in  asynchronous active-low reset
//   s1, s2         in  raw buttons, active-low, bouncing
//   pressed        out debounced levels, bit0 = s1, bit1 = s2
//   press_pulse    out one-cycle pulse per accepted press
//   release_pulse  out one-cycle pulse per accepted release
//   long_pulse     out one-cycle pulse when a press is held LONG_CYCLES
//   chord_pulse    out one-cycle pulse when pressed becomes 2'b11
// ---------------------------------------------------------------------------
module board_test_button_conditioner
   import board_test_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
   input  logic       int_clock,
   input  logic       rst,
   input  logic       s1,
   input  logic       s2,
   output logic [1:0] pressed,
   output logic [1:0] press_pulse,
   output logic [1:0] release_pulse,
   output logic [1:0] long_pulse,
   output logic       chord_pulse
);

   logic [1:0] pressed_nxt;
   logic       chord_q;

   board_test_button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
   ) u_ch_s1 (
      .int_clock       (int_clock),
      .rst             (rst),
      .btn_i           (s1),
      .pressed_o       (pressed[0]),
      .pressed_d_o     (pressed_nxt[0]),
      .press_pulse_o   (press_pulse[0]),
      .release_pulse_o (release_pulse[0]),
      .long_pulse_o    (long_pulse[0])
   );

   board_test_button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
   ) u_ch_s2 (
      .int_clock       (int_clock),
      .rst             (rst),
      .btn_i           (s2),
      .pressed_o       (pressed[1]),
      .pressed_d_o     (pressed_nxt[1]),
      .press_pulse_o   (press_pulse[1]),
      .release_pulse_o (release_pulse[1]),
      .long_pulse_o    (long_pulse[1])
   );

   // Looking at the channels' next-state level keeps the chord pulse in the
   // same cycle as the press pulse that completes the chord.
   always_ff @(posedge int_clock or negedge rst) begin
      if (!rst) chord_q <= 1'b0;
      else      chord_q <= (&pressed_nxt) & ~(&pressed);
   end

   assign chord_pulse = chord_q;

endmodule

// File: tb/tb_board_test_button_conditioner.sv
module tb_board_test_button_conditioner;

   localparam int DB = 8;
   localparam int LC = 32;
   localparam int W  = 9;

   // ---------------- clock / reset ----------------
   logic       int_clock = 1'b0;
   logic       rst;
   logic       s1, s2;
   logic [1:0] pressed, press_pulse, release_pulse, long_pulse;
   logic       chord_pulse;

   always #5 int_clock = ~int_clock;

   board_test_button_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LC)
   ) dut (
      .int_clock     (int_clock),
      .rst           (rst),
      .s1            (s1),
      .s2            (s2),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .chord_pulse   (chord_pulse)
   );

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [W-1:0] exp_q[$];

   // Reference model: raw input delayed two samples, accepted level change
   // after DB equal consecutive samples, long pulse LC cycles after press.
   logic [1:0] m_r1, m_r2, m_pressed, m_long_done, m_prev_sp, m_run_val;
   int         m_run_len[2];
   int         m_press_at[2];

   // Observed-event statistics for directed cycle checks.
   int n_press[2], at_press[2], n_rel[2], at_rel[2], n_long[2], at_long[2];
   int n_chord, at_chord;
   logic [1:0] seen_pressed;

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_r1        = 2'b11;
      m_r2        = 2'b11;
      m_pressed   = 2'b00;
      m_long_done = 2'b00;
      m_prev_sp   = 2'b00;
      m_run_val   = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
         m_run_len[ch]  = 0;
         m_press_at[ch] = 0;
      end
   endtask

   task automatic model_edge();
      logic [1:0] old_p, pp, rp, lp;
      logic       chord, raw, sp;
      cyc++;
      if (!rst) begin
         model_reset();
         exp_q.push_back('0);
         return;
      end
      old_p = m_pressed;
      pp = '0; rp = '0; lp = '0;
      for (int ch = 0; ch < 2; ch++) begin
         raw = (ch == 0) ? s1 : s2;
         sp  = ~m_r2[ch];
         m_r2[ch] = m_r1[ch];
         m_r1[ch] = raw;
         if (sp == m_run_val[ch]) m_run_len[ch]++;
         else begin
            m_run_val[ch] = sp;
            m_run_len[ch] = 1;
         end
         if (!m_pressed[ch] && sp && m_run_len[ch] >= DB) begin
            m_pressed[ch]   = 1'b1;
            pp[ch]          = 1'b1;
            m_press_at[ch]  = cyc;
            m_long_done[ch] = 1'b0;
         end else if (m_pressed[ch] && !sp && m_run_len[ch] >= DB) begin
            m_pressed[ch] = 1'b0;
            rp[ch]        = 1'b1;
         end else if (m_pressed[ch] && !m_long_done[ch] && sp && m_prev_sp[ch]
                      && (cyc - m_press_at[ch]) >= LC) begin
            lp[ch]          = 1'b1;
            m_long_done[ch] = 1'b1;
         end
         m_prev_sp[ch] = sp;
      end
      chord = (m_pressed == 2'b11) && (old_p != 2'b11);
      exp_q.push_back({m_pressed, pp, rp, lp, chord});
   endtask

   task automatic check_outputs();
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk2("pressed",       pressed,             e[8:7]);
      chk2("press_pulse",   press_pulse,         e[6:5]);
      chk2("release_pulse", release_pulse,       e[4:3]);
      chk2("long_pulse",    long_pulse,          e[2:1]);
      chk2("chord_pulse",   {1'b0, chord_pulse}, {1'b0, e[0]});
      for (int ch = 0; ch < 2; ch++) begin
         if (press_pulse[ch])   begin n_press[ch]++; at_press[ch] = cyc; end
         if (release_pulse[ch]) begin n_rel[ch]++;   at_rel[ch]   = cyc; end
         if (long_pulse[ch])    begin n_long[ch]++;  at_long[ch]  = cyc; end
         if (pressed[ch])       seen_pressed[ch] = 1'b1;
      end
      if (chord_pulse) begin n_chord++; at_chord = cyc; end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge int_clock);
      model_edge();
      @(negedge int_clock);
      check_outputs();
   endtask

   task automatic clear_stats();
      for (int ch = 0; ch < 2; ch++) begin
         n_press[ch] = 0; at_press[ch] = -1;
         n_rel[ch]   = 0; at_rel[ch]   = -1;
         n_long[ch]  = 0; at_long[ch]  = -1;
      end
      n_chord = 0; at_chord = -1;
      seen_pressed = 2'b00;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int mark;
      int hold[2];
      model_reset();
      clear_stats();
      rst = 1'b0; s1 = 1'b1; s2 = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      repeat (5) tick();

      // Clean press / release on s1
      clear_stats(); mark = cyc;
      s1 = 1'b0; repeat (20) tick();
      s1 = 1'b1; repeat (15) tick();
      chk_int("clean_press_count",   n_press[0], 1);
      chk_int("clean_press_cycle",   at_press[0] - mark, 10);
      chk_int("clean_release_count", n_rel[0], 1);
      chk_int("clean_release_cycle", at_rel[0] - mark, 30);

      // Bounce ending high: nothing accepted
      clear_stats();
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) s1 = ~s1;
         tick();
      end
      s1 = 1'b1; repeat (20) tick();
      chk_int("bounce_hi_press",   n_press[0], 0);
      chk_int("bounce_hi_release", n_rel[0], 0);
      chk_int("bounce_hi_level",   int'(seen_pressed[0]), 0);

      // Bounce ending low: one press 10 cycles after the final edge
      clear_stats(); mark = cyc;
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) s1 = ~s1;
         tick();
      end
      s1 = 1'b0; repeat (15) tick();
      chk_int("bounce_lo_press_count", n_press[0], 1);
      chk_int("bounce_lo_press_cycle", at_press[0] - mark, 50);
      s1 = 1'b1; repeat (15) tick();

      // Long hold on s2 with a short release glitch after the long pulse
      clear_stats(); mark = cyc;
      s2 = 1'b0; repeat (45) tick();
      s2 = 1'b1; repeat (4) tick();
      s2 = 1'b0; repeat (11) tick();
      s2 = 1'b1; repeat (15) tick();
      chk_int("long_press_cycle",    at_press[1] - mark, 10);
      chk_int("long_count",          n_long[1], 1);
      chk_int("long_cycle",          at_long[1] - mark, 42);
      chk_int("long_release_count",  n_rel[1], 1);
      chk_int("long_release_cycle",  at_rel[1] - mark, 70);

      // Chord from staggered presses
      clear_stats(); mark = cyc;
      s1 = 1'b0; repeat (5) tick();
      s2 = 1'b0; repeat (20) tick();
      chk_int("chord_stagger_count", n_chord, 1);
      chk_int("chord_stagger_cycle", at_chord - mark, 15);
      s1 = 1'b1; s2 = 1'b1; repeat (15) tick();

      // Chord from simultaneous presses
      clear_stats(); mark = cyc;
      s1 = 1'b0; s2 = 1'b0; repeat (15) tick();
      chk_int("chord_same_count", n_chord, 1);
      chk_int("chord_same_cycle", at_chord - mark, 10);
      chk_int("chord_same_p0",    at_press[0] - mark, 10);
      chk_int("chord_same_p1",    at_press[1] - mark, 10);
      s1 = 1'b1; s2 = 1'b1; repeat (15) tick();

      // Reset while s1 is held
      clear_stats();
      s1 = 1'b0; repeat (15) tick();
      rst = 1'b0;
      #1;
      chk2("rst_async_pressed",       pressed,       2'b00);
      chk2("rst_async_press_pulse",   press_pulse,   2'b00);
      chk2("rst_async_release_pulse", release_pulse, 2'b00);
      chk2("rst_async_long_pulse",    long_pulse,    2'b00);
      chk2("rst_async_chord",         {1'b0, chord_pulse}, 2'b00);
      model_reset();
      repeat (3) tick();
      rst = 1'b1;
      clear_stats(); mark = cyc;
      repeat (12) tick();
      chk_int("rst_repress_count", n_press[0], 1);
      chk_int("rst_repress_cycle", at_press[0] - mark, 10);
      s1 = 1'b1; repeat (15) tick();

      // Randomised bouncing presses on both buttons, with one reset pulse
      hold[0] = 0; hold[1] = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) rst = 1'b0;
         if (i == 1503) rst = 1'b1;
         for (int ch = 0; ch < 2; ch++) begin
            if (hold[ch] == 0) begin
               if (ch == 0) s1 = ~s1;
               else         s2 = ~s2;
               hold[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                      : int'($urandom_range(6, 90));
            end
            hold[ch]--;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_test_button_conditioner.md
# board_test_button_conditioner

Conditions the two raw push-buttons of the board-test design, s1 and s2, into clean per-button events. These events drive the LED pattern logic.
- Each button is synchronised to int_clock, debounced, and classified as press, release or long-press.
- A chord event is produced when both buttons are held together.
- The block sits between the button pins and every consumer of button state.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50_000: consecutive stable synchronised samples required to accept a level change (20 ms at 2.5 MHz); legal range ≥ 2.
- LONG_CYCLES, default 2_500_000: cycles a press must be held, counted from the rise of pressed, before long_pulse; must exceed DEBOUNCE_CYCLES.

Ports:
- int_clock  in   1  internal oscillator clock, all logic on posedge
- rst        in   1  reset, asynchronous, active-low
- s1         in   1  raw button 1, active-low, asynchronous, bouncing
- s2         in   1  raw button 2, active-low, asynchronous, bouncing
- pressed    out  2  debounced level, active-high; bit0 = s1, bit1 = s2
- press_pulse    out  2  one-cycle pulse on accepted press
- release_pulse  out  2  one-cycle pulse on accepted release
- long_pulse     out  2  one-cycle pulse when held LONG_CYCLES
- chord_pulse    out  1  one-cycle pulse when both pressed bits become 1

## Operation
- Synchroniser: a 2-FF chain per input, reset value 1 (released). Downstream logic uses the inverted output, sp = 1 meaning pushed.
- Per-channel FSM states:
  - IDLE: sp=1 → PRESS_WAIT and debounce count cleared.
  - PRESS_WAIT: sp=0 → IDLE with no pulse. On count reaching DEBOUNCE_CYCLES → HELD; pressed←1, press_pulse=1.
  - HELD: sp=0 → RELEASE_WAIT. Long counter reaching LONG_CYCLES → LONG_HELD; long_pulse=1.
  - LONG_HELD: sp=0 → RELEASE_WAIT.
  - RELEASE_WAIT: sp=1 → return to the originating HELD or LONG_HELD, with no pulse and the long counter intact. On count reaching DEBOUNCE_CYCLES → IDLE; pressed←0, release_pulse=1.
- Debounce counter:
  - cleared on every state change and on every bounce;
  - width $clog2(DEBOUNCE_CYCLES+1);
  - saturating, never wraps.
- Long counter:
  - cleared on entry to HELD;
  - increments every cycle while pressed=1, including RELEASE_WAIT;
  - saturates at LONG_CYCLES;
  - width $clog2(LONG_CYCLES+1).
- long_pulse fires at most once per press.
- chord_pulse: asserted on the cycle pressed becomes 2'b11 from any other value. This includes both bits rising in the same cycle. Release of either button re-arms it.
- Channels are fully independent. Simultaneous events on both channels each produce their own pulses in the same cycle.

## Timing
- All outputs are registered. Reset values: pressed=0, all pulse outputs=0, FSMs in IDLE, counters=0, synchroniser flops=1.
- Latency from a clean raw falling edge to pressed rising and press_pulse is exactly DEBOUNCE_CYCLES+2 cycles. Release latency is the same.
- long_pulse occurs exactly LONG_CYCLES cycles after the cycle in which press_pulse was asserted.
- Pulses are exactly one cycle wide. A new press cannot produce press_pulse sooner than 2·DEBOUNCE_CYCLES cycles after the previous one.
- Reset mid-operation:
  - all state is discarded immediately and no pulse is emitted;
  - a button still held when rst deasserts is treated as a fresh press, so press_pulse fires DEBOUNCE_CYCLES+2 cycles after reset release.
- Bounce shorter than DEBOUNCE_CYCLES consecutive samples produces no output change.

## Structure
- Package board_test_pkg holds:
  - btn_state_e (IDLE, PRESS_WAIT, HELD, LONG_HELD, RELEASE_WAIT);
  - the default DEBOUNCE_CYCLES and LONG_CYCLES constants.
- Sub-module board_test_button_channel contains the synchroniser, FSM and both counters. It has the same parameters and one button's ports.
- The top instantiates board_test_button_channel twice and adds the chord_pulse register.
- Elaboration-time assertions check the parameter legality rules.

## Test plan
Directed tests use DEBOUNCE_CYCLES=8 and LONG_CYCLES=32.
- Clean press: s1 low at cycle 0 → pressed[0] rises and press_pulse[0]=1 at cycle 10 only. Release at cycle 20 → release_pulse[0]=1 at cycle 30.
- Bounce: s1 toggles every 3 cycles for 40 cycles then stays high → no pulses and pressed=0 throughout. The same pattern ending low → exactly one press_pulse, 10 cycles after the final edge.
- Long hold: s2 held 60 cycles → press_pulse[1] at cycle 10, long_pulse[1] at cycle 42, single. A 4-cycle release glitch at cycle 45 → no release_pulse and no second long_pulse.
- Chord: s1 low at cycle 0 and s2 low at cycle 5 → chord_pulse at cycle 15. Both released then both pressed in the same cycle → chord_pulse once, coinciding with both press_pulse bits.
- Reset mid-press: rst low for 3 cycles while s1 is held in HELD → all outputs 0 immediately. press_pulse[0] fires 10 cycles after rst rises.
